// File: rtl/alu_exec_pipe.sv
// ---------------------------------------------------------------------------
// alu_exec_pipe -- integer execution unit for one issue slot of the LEGv8 core.
//
// Accepts one op per cycle through a valid/ready handshake, carries a ROB tag
// alongside it, and presents a registered result together with NZCV flags and
// an illegal-op indication. AND/OR/ADD/SUB/XOR/LSL/LSR/MOVB and illegal
// opcodes complete one cycle after acceptance. With ALU_MUL_EN defined,
// opcode 1000 runs an iterative shift-add multiply taking WIDTH cycles.
// Without ALU_MUL_EN, opcode 1000 is reported as illegal and no multiply
// hardware exists.
//
// Ports:
//   CLK, RESET            clock (rising edge) and synchronous active-high reset
//   FLUSH                 kills in-flight and held work, blocks acceptance
//   IN_VALID / IN_READY   input handshake
//   A, B, CONTROL, IN_TAG operands, opcode, ROB tag
//   OUT_VALID / OUT_READY output handshake
//   RESULT, OUT_TAG       registered result and its tag
//   ZEROFLAG, NEGFLAG, CARRYFLAG, OVFLAG, ILLEGAL  registered status
//
// Optional feature macro: ALU_MUL_EN
// ---------------------------------------------------------------------------
module alu_exec_pipe #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 6
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             FLUSH,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [3:0]       CONTROL,
   input  logic [TAG_W-1:0] IN_TAG,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   output logic [WIDTH-1:0] RESULT,
   output logic [TAG_W-1:0] OUT_TAG,
   output logic             ZEROFLAG,
   output logic             NEGFLAG,
   output logic             CARRYFLAG,
   output logic             OVFLAG,
   output logic             ILLEGAL
);
   localparam int SHAMT_W = $clog2(WIDTH);

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SUB  = 4'b0011;
   localparam logic [3:0] OP_XOR  = 4'b0100;
   localparam logic [3:0] OP_LSL  = 4'b0101;
   localparam logic [3:0] OP_LSR  = 4'b0110;
   localparam logic [3:0] OP_MOVB = 4'b0111;
`ifdef ALU_MUL_EN
   localparam logic [3:0] OP_MUL  = 4'b1000;
`endif

   // Output register
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic             zero_q, zero_d, neg_q, neg_d;
   logic             carry_q, carry_d, ovf_q, ovf_d;
   logic             illegal_q, illegal_d;

   // Single-cycle datapath
   logic [WIDTH:0]   add_x_s, sub_x_s;
   logic [SHAMT_W-1:0] shamt_s;
   logic [WIDTH-1:0] alu_res_s;
   logic             alu_c_s, alu_v_s, alu_ill_s;

   logic             is_mul_s, idle_s, out_free_s, accept_s;

`ifdef ALU_MUL_EN
   typedef enum logic [0:0] {S_IDLE, S_MUL_RUN} state_e;
   state_e           state_q, state_d;
   logic [WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
   logic [WIDTH-1:0] acc_step_s;
   logic [SHAMT_W-1:0] cnt_q, cnt_d;
   logic [TAG_W-1:0] mtag_q, mtag_d;
   logic             mul_last_s, mul_done_s;

   assign is_mul_s   = (CONTROL == OP_MUL);
   assign idle_s     = (state_q == S_IDLE);
   // One shift-add step: the multiplier's current LSB selects the multiplicand.
   assign acc_step_s = acc_q + (mplier_q[0] ? mcand_q : '0);
   assign mul_last_s = (state_q == S_MUL_RUN) && (cnt_q == SHAMT_W'(WIDTH - 1));
   // The final step only retires when the output register can take it.
   assign mul_done_s = mul_last_s && out_free_s && !FLUSH;
`else
   assign is_mul_s   = 1'b0;
   assign idle_s     = 1'b1;
`endif

   assign out_free_s = !out_valid_q || OUT_READY;
   assign IN_READY   = !FLUSH && idle_s && out_free_s;
   assign accept_s   = IN_VALID && IN_READY;

   // Single-cycle ALU result and flags for the op currently presented
   always_comb begin
      add_x_s   = {1'b0, A} + {1'b0, B};
      sub_x_s   = {1'b0, A} - {1'b0, B};
      shamt_s   = B[SHAMT_W-1:0];
      alu_res_s = '0;
      alu_c_s   = 1'b0;
      alu_v_s   = 1'b0;
      alu_ill_s = 1'b0;
      case (CONTROL)
         OP_AND:  alu_res_s = A & B;
         OP_OR:   alu_res_s = A | B;
         OP_ADD: begin
            alu_res_s = add_x_s[WIDTH-1:0];
            alu_c_s   = add_x_s[WIDTH];
            alu_v_s   = (A[WIDTH-1] == B[WIDTH-1]) && (add_x_s[WIDTH-1] != A[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res_s = sub_x_s[WIDTH-1:0];
            // Bit WIDTH of the extended difference is the borrow.
            alu_c_s   = ~sub_x_s[WIDTH];
            alu_v_s   = (A[WIDTH-1] != B[WIDTH-1]) && (sub_x_s[WIDTH-1] != A[WIDTH-1]);
         end
         OP_XOR:  alu_res_s = A ^ B;
         OP_LSL:  alu_res_s = A << shamt_s;
         OP_LSR:  alu_res_s = A >> shamt_s;
         OP_MOVB: alu_res_s = B;
`ifdef ALU_MUL_EN
         // Produced by the multiply FSM, never through this path.
         OP_MUL:  alu_ill_s = 1'b0;
`endif
         default: alu_ill_s = 1'b1;
      endcase
   end

   // Output register next state: flush, single-cycle load, multiply load, drain
   always_comb begin
      out_valid_d = out_valid_q;
      result_d    = result_q;
      tag_d       = tag_q;
      zero_d      = zero_q;
      neg_d       = neg_q;
      carry_d     = carry_q;
      ovf_d       = ovf_q;
      illegal_d   = illegal_q;
      if (FLUSH) begin
         out_valid_d = 1'b0;
      end else if (accept_s && !is_mul_s) begin
         out_valid_d = 1'b1;
         result_d    = alu_res_s;
         tag_d       = IN_TAG;
         zero_d      = (alu_res_s == '0);
         neg_d       = alu_res_s[WIDTH-1];
         carry_d     = alu_c_s;
         ovf_d       = alu_v_s;
         illegal_d   = alu_ill_s;
`ifdef ALU_MUL_EN
      end else if (mul_done_s) begin
         out_valid_d = 1'b1;
         result_d    = acc_step_s;
         tag_d       = mtag_q;
         zero_d      = (acc_step_s == '0);
         neg_d       = acc_step_s[WIDTH-1];
         carry_d     = 1'b0;
         ovf_d       = 1'b0;
         illegal_d   = 1'b0;
`endif
      end else if (OUT_READY) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end
   end

`ifdef ALU_MUL_EN
   // Multiply FSM next state and shift-add datapath
   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      mtag_d   = mtag_q;
      case (state_q)
         S_IDLE: begin
            if (accept_s && is_mul_s) begin
               state_d  = S_MUL_RUN;
               mcand_d  = A;
               mplier_d = B;
               acc_d    = '0;
               cnt_d    = '0;
               mtag_d   = IN_TAG;
            end else begin
               state_d  = S_IDLE;
            end
         end
         S_MUL_RUN: begin
            if (FLUSH) begin
               state_d = S_IDLE;
            end else if (mul_last_s) begin
               // Hold the last step (no accumulate) until the result retires.
               state_d = out_free_s ? S_IDLE : S_MUL_RUN;
            end else begin
               acc_d    = acc_step_s;
               mcand_d  = mcand_q << 1;
               mplier_d = mplier_q >> 1;
               cnt_d    = cnt_q + SHAMT_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end
`endif

   // State registers with synchronous reset
   always_ff @(posedge CLK) begin
      if (RESET) begin
         out_valid_q <= 1'b0;
         result_q    <= '0;
         tag_q       <= '0;
         zero_q      <= 1'b0;
         neg_q       <= 1'b0;
         carry_q     <= 1'b0;
         ovf_q       <= 1'b0;
         illegal_q   <= 1'b0;
`ifdef ALU_MUL_EN
         state_q     <= S_IDLE;
         mcand_q     <= '0;
         mplier_q    <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         mtag_q      <= '0;
`endif
      end else begin
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         tag_q       <= tag_d;
         zero_q      <= zero_d;
         neg_q       <= neg_d;
         carry_q     <= carry_d;
         ovf_q       <= ovf_d;
         illegal_q   <= illegal_d;
`ifdef ALU_MUL_EN
         state_q     <= state_d;
         mcand_q     <= mcand_d;
         mplier_q    <= mplier_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         mtag_q      <= mtag_d;
`endif
      end
   end

   assign OUT_VALID = out_valid_q;
   assign RESULT    = result_q;
   assign OUT_TAG   = tag_q;
   assign ZEROFLAG  = zero_q;
   assign NEGFLAG   = neg_q;
   assign CARRYFLAG = carry_q;
   assign OVFLAG    = ovf_q;
   assign ILLEGAL   = illegal_q;

endmodule

// File: doc/alu_exec_pipe.md
Name: alu_exec_pipe

Overview:
- Parametrised, pipelined successor to the combinational ALU, built as the integer execution unit for one issue slot of the superscalar LEGv8 core.
- Accepts one op per cycle through a valid/ready handshake and carries a ROB tag alongside the op.
- Produces a registered result plus NZCV flags.
- Adds shifts, an iterative multi-cycle multiply, an illegal-op indication and a pipeline flush.

Parameters:
- WIDTH, 32, datapath width in bits (power of 2, 8..64).
- TAG_W, 6, width of the ROB tag carried alongside each op.
- SHAMT_W (localparam), $clog2(WIDTH), width of the shift amount.

Ports:
- CLK  in  1  clock, all logic on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- FLUSH  in  1  kill all in-flight and held work (branch mispredict).
- IN_VALID  in  1  op presented.
- IN_READY  out  1  unit can accept an op this cycle.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B (low SHAMT_W bits are the shift amount for shifts).
- CONTROL  in  4  opcode.
- IN_TAG  in  TAG_W  ROB tag.
- OUT_VALID  out  1  result valid.
- OUT_READY  in  1  consumer accepts the result.
- RESULT  out  WIDTH  result.
- OUT_TAG  out  TAG_W  tag of the result.
- ZEROFLAG  out  1  RESULT == 0.
- NEGFLAG  out  1  RESULT[WIDTH-1].
- CARRYFLAG  out  1  carry flag.
- OVFLAG  out  1  signed overflow flag.
- ILLEGAL  out  1  opcode undefined or not compiled in.

Behaviour:
- Reset: one clock, synchronous, active-high. With RESET high at a rising edge:
  - OUT_VALID=0, RESULT=0, OUT_TAG=0, all flags 0, ILLEGAL=0.
  - Multiply FSM returns to IDLE.
  - RESET has priority over FLUSH and over any handshake.
- Opcodes:
  - 0000 AND; 0001 OR; 0010 ADD; 0011 SUB (A-B); 0100 XOR.
  - 0101 LSL (A << B[SHAMT_W-1:0]); 0110 LSR (logical right shift by the same amount); 0111 MOVB (RESULT=B).
  - 1000 MUL (low WIDTH bits of A*B, unsigned).
  - 1001-1111 illegal.
- Handshake:
  - Accept when IN_VALID && IN_READY at a rising edge.
  - Complete when OUT_VALID && OUT_READY.
  - IN_READY = !FLUSH && state==IDLE && (!OUT_VALID || OUT_READY).
  - While OUT_VALID && !OUT_READY, RESULT, OUT_TAG and all flags hold stable.
- Latency:
  - Non-MUL op accepted at edge k: OUT_VALID=1 after edge k.
  - Back-to-back throughput is 1 op/cycle when OUT_READY is held high.
- Flags:
  - ADD: CARRYFLAG = carry-out; OVFLAG = (A[msb]==B[msb]) && (RESULT[msb]!=A[msb]).
  - SUB: CARRYFLAG = !borrow, i.e. 1 when A >= B unsigned; OVFLAG = (A[msb]!=B[msb]) && (RESULT[msb]!=A[msb]).
  - All other ops: CARRYFLAG=0, OVFLAG=0.
  - ZEROFLAG and NEGFLAG are always derived from RESULT.
- Illegal op:
  - Accepted normally with latency 1.
  - RESULT=0, ZEROFLAG=1, other flags 0, ILLEGAL=1.
- Multiply FSM, states IDLE -> MUL_RUN -> IDLE:
  - On accepting MUL: latch A, B and IN_TAG; clear the accumulator; set counter=0; enter MUL_RUN.
  - MUL_RUN: shift-add one multiplier bit per cycle. After WIDTH cycles, load the output register and return to IDLE.
  - MUL accepted at edge k gives OUT_VALID=1 after edge k+WIDTH.
  - IN_READY=0 throughout MUL_RUN.
  - An older result held in the output register may drain during MUL_RUN.
  - MUL_RUN cannot complete while OUT_VALID && !OUT_READY; it stalls in its last cycle until the output register frees.
- FLUSH, at a rising edge:
  - OUT_VALID -> 0; FSM -> IDLE; no op accepted that cycle.
  - A result completing on the same edge is discarded.
  - FLUSH has priority over OUT_READY.
- Wrap-around: ADD, SUB and MUL truncate to WIDTH bits. A shift amount uses only B[SHAMT_W-1:0], so LSL by WIDTH acts as a shift by 0.

Optional Feature:
- Macro: ALU_MUL_EN.
- Defined:
  - Opcode 1000 is the iterative multiply described above.
- Undefined:
  - No MUL datapath or FSM states are synthesised; the FSM is permanently IDLE.
  - Opcode 1000 is treated as illegal (latency 1, RESULT=0, ILLEGAL=1).

Test Plan:
- WIDTH=32, OUT_READY=1: ADD 10+20 -> 30, C=0; SUB 30-10 -> 20, C=1; SUB 5-5 -> 0, ZEROFLAG=1, C=1. Each OUT_VALID one cycle after accept.
- ADD 0x7FFFFFFF+1 -> 0x80000000, OVFLAG=1, NEGFLAG=1; ADD 0xFFFFFFFF+1 -> 0, CARRYFLAG=1, ZEROFLAG=1; SUB 0-1 -> 0xFFFFFFFF, C=0.
- LSL 0x1 by B=4 -> 0x10; LSR 0x80000000 by 31 -> 1; LSL 0x1 by B=32 -> 0x1; CONTROL=1111, tag 5 -> RESULT=0, ILLEGAL=1, OUT_TAG=5.
- Backpressure: 3 back-to-back ADDs with OUT_READY low for 4 cycles -> IN_READY=0 after the first accept, RESULT/OUT_TAG stable, all 3 results delivered in order once OUT_READY rises.
- ALU_MUL_EN: MUL 1234*5678 -> 7006652, OUT_VALID exactly 32 cycles after accept, IN_READY=0 during; MUL 0xFFFFFFFF*2 -> 0xFFFFFFFE. Without the macro, opcode 1000 gives ILLEGAL=1.
- FLUSH asserted in cycle 10 of a MUL -> OUT_VALID stays 0, IN_READY=1 next cycle, following ADD 1+1 -> 2. RESET mid-MUL gives the same recovery with all outputs zeroed.
